// File: rtl/adlib_pkg.sv
// Shared constants and helpers for the AdLib FM channel datapath.
package adlib_pkg;

    // Register groups: a[7:5] for the operator groups, a[7:4] for the channel groups.
    localparam logic [2:0] GRP_20 = 3'd1;
    localparam logic [2:0] GRP_40 = 3'd2;
    localparam logic [2:0] GRP_60 = 3'd3;
    localparam logic [2:0] GRP_80 = 3'd4;
    localparam logic [2:0] GRP_E0 = 3'd7;
    localparam logic [3:0] GRP_A0 = 4'hA;
    localparam logic [3:0] GRP_B0 = 4'hB;
    localparam logic [3:0] GRP_C0 = 4'hC;

    localparam int unsigned WAVE_W  = 4;
    localparam int unsigned PHASE_W = 6;
    localparam int unsigned MAG1_W  = 14;
    localparam int unsigned MAG2_W  = 15;
    localparam int unsigned SUM_W   = 17;

    // Sign-magnitude (15-bit magnitude) to 16-bit two's complement.
    function automatic logic signed [15:0] sm_to_signed(input logic neg, input logic [14:0] mag);
        logic signed [15:0] m;
        m = $signed({1'b0, mag});
        return neg ? -m : m;
    endfunction

    // Saturate the 17-bit stage-2 sum into 16-bit signed range.
    function automatic logic signed [15:0] clamp16(input logic signed [16:0] x);
        if (x > 17'sd32767)
            return 16'sh7FFF;
        else if (x < -17'sd32768)
            return 16'sh8000;
        else
            return 16'(x);
    endfunction

    // Two's complement to offset-binary (MSB inverted).
    function automatic logic [15:0] to_offset16(input logic signed [15:0] v);
        return {~v[15], v[14:0]};
    endfunction

endpackage

// File: rtl/adlib_channel_fb_if.sv
// Register bus, operator-block links and sample output of one FM channel.
interface adlib_channel_fb_if #(
    parameter int unsigned OUT_W = 16
);
    import adlib_pkg::*;

    logic [7:0]         a;
    logic [7:0]         din;
    logic               regwr;
    logic               sample_stb;

    logic [WAVE_W-1:0]  op1_wave;
    logic [WAVE_W-1:0]  op2_wave;
    logic               op1_sign;
    logic               op2_sign;
    logic [MAG1_W-1:0]  op1_mag;
    logic [MAG2_W-1:0]  op2_mag;

    logic [PHASE_W-1:0] op1_phase_c;
    logic [PHASE_W-1:0] op2_phase_c;
    logic               op1_wr_c;
    logic               op2_wr_c;
    logic               ch_wr_c;

    logic [OUT_W-1:0]   result;
    logic               result_valid;

    modport master (
        output a, din, regwr, sample_stb,
        output op1_wave, op2_wave, op1_sign, op2_sign, op1_mag, op2_mag,
        input  op1_phase_c, op2_phase_c, op1_wr_c, op2_wr_c, ch_wr_c,
        input  result, result_valid
    );

    modport slave (
        input  a, din, regwr, sample_stb,
        input  op1_wave, op2_wave, op1_sign, op2_sign, op1_mag, op2_mag,
        output op1_phase_c, op2_phase_c, op1_wr_c, op2_wr_c, ch_wr_c,
        output result, result_valid
    );
endinterface

// File: rtl/adlib_channel_fb_history.sv
// Op1 feedback history (h0/h1) and phase-offset computation.
import adlib_pkg::*;

module adlib_fb_history (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_stb,
    input  logic                i_clr,
    input  logic signed [14:0]  i_c1,
    input  logic [2:0]          i_fb,
    output logic [PHASE_W-1:0]  o_fbofs_c
);
    logic signed [14:0] r_h0;
    logic signed [14:0] r_h1;
    logic signed [15:0] w_fbsum;
    logic signed [15:0] w_fbshift;

    // History shift on sample strobe; key-on clear takes priority.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_h0 <= '0;
            r_h1 <= '0;
        end else if (i_stb) begin
            r_h1 <= r_h0;
            r_h0 <= i_c1;
        end
    end

    // Feedback offset from the summed history, scaled by fb.
    always_comb begin
        w_fbsum   = $signed({r_h0[14], r_h0}) + $signed({r_h1[14], r_h1});
        w_fbshift = w_fbsum >>> (4'd15 - {1'b0, i_fb});
        o_fbofs_c = (i_fb == 3'd0) ? '0 : w_fbshift[PHASE_W-1:0];
    end
endmodule

// File: rtl/adlib_channel_fb.sv
// Two-operator FM channel: register decode, op1 feedback, two-stage output pipeline.
// Optional feature macro: ADLIB_FEEDBACK_EN (feedback register, history and offset).
import adlib_pkg::*;

module adlib_channel_fb #(
    parameter int unsigned N     = 0,
    parameter int unsigned OPN   = 0,
    parameter int unsigned OUT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    adlib_channel_fb_if.slave  bus
);
    localparam logic [OUT_W-1:0] MIDPOINT = {1'b1, {(OUT_W-1){1'b0}}};

    logic                   r_alg;
    logic signed [14:0]     r_s1;
    logic signed [15:0]     r_s2;
    logic                   r_v1;

    logic                   w_op_grp;
    logic                   w_ch_sel;
    logic                   w_cn_wr;
    logic                   w_s2_neg;
    logic signed [14:0]     w_c1;
    logic signed [16:0]     w_sum;
    logic signed [15:0]     w_v;
    logic [15:0]            w_ob16;
    logic [OUT_W-1:0]       w_res;
    logic [PHASE_W-1:0]     w_fbofs;
    logic [PHASE_W-1:0]     w_op2_base;

    // Register decode toward the operator/oscillator blocks.
    assign w_op_grp = (bus.a[7:5] == GRP_20) || (bus.a[7:5] == GRP_40) ||
                      (bus.a[7:5] == GRP_60) || (bus.a[7:5] == GRP_80) ||
                      (bus.a[7:5] == GRP_E0);
    assign w_ch_sel = (bus.a[3:0] == 4'(N));
    assign bus.op1_wr_c = bus.regwr && w_op_grp && (bus.a[4:0] == 5'(OPN));
    assign bus.op2_wr_c = bus.regwr && w_op_grp && (bus.a[4:0] == 5'(OPN + 3));
    assign bus.ch_wr_c  = bus.regwr && w_ch_sel &&
                          ((bus.a[7:4] == GRP_A0) || (bus.a[7:4] == GRP_B0) ||
                           (bus.a[7:4] == GRP_C0));
    assign w_cn_wr      = bus.regwr && w_ch_sel && (bus.a[7:4] == GRP_C0);

    assign w_c1 = 15'(sm_to_signed(bus.op1_sign, {1'b0, bus.op1_mag}));

`ifdef ADLIB_FEEDBACK_EN
    logic [2:0] r_fb;
    logic       r_key;
    logic       w_bn_wr;
    logic       w_key_rise;

    assign w_bn_wr    = bus.regwr && w_ch_sel && (bus.a[7:4] == GRP_B0);
    assign w_key_rise = w_bn_wr && bus.din[5] && !r_key;

    // Feedback amount and key state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fb  <= '0;
            r_key <= 1'b0;
        end else begin
            if (w_cn_wr) r_fb  <= bus.din[3:1];
            if (w_bn_wr) r_key <= bus.din[5];
        end
    end

    adlib_fb_history u_hist (
        .clk       (clk),
        .reset     (reset),
        .i_stb     (bus.sample_stb),
        .i_clr     (w_key_rise),
        .i_c1      (w_c1),
        .i_fb      (r_fb),
        .o_fbofs_c (w_fbofs)
    );
`else
    assign w_fbofs = '0;
`endif

    // Algorithm select.
    always_ff @(posedge clk) begin
        if (reset)
            r_alg <= 1'b0;
        else if (w_cn_wr)
            r_alg <= bus.din[0];
    end

    // Multiplier phase inputs (modulo 64).
    assign w_op2_base      = {bus.op2_wave, 2'b00};
    assign bus.op1_phase_c = {bus.op1_wave, 2'b00} + w_fbofs;
    assign bus.op2_phase_c = r_alg ? w_op2_base : w_op2_base + bus.op1_mag[13:8];

    assign w_s2_neg = r_alg ? bus.op2_sign : (bus.op1_sign ^ bus.op2_sign);

    // Stage 1: capture the two output terms on the sample strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= bus.sample_stb;
            if (bus.sample_stb) begin
                r_s1 <= r_alg ? w_c1 : '0;
                r_s2 <= sm_to_signed(w_s2_neg, bus.op2_mag);
            end
        end
    end

    // Stage 2 datapath: sum, saturate, convert to offset-binary, rescale.
    assign w_sum  = $signed({{2{r_s1[14]}}, r_s1}) + $signed({r_s2[15], r_s2});
    assign w_v    = clamp16(w_sum);
    assign w_ob16 = to_offset16(w_v);

    generate
        if (OUT_W > 16) begin : g_wide
            assign w_res = {w_ob16, {(OUT_W-16){1'b0}}};
        end else if (OUT_W == 16) begin : g_same
            assign w_res = w_ob16;
        end else begin : g_narrow
            assign w_res = w_ob16[15:16-OUT_W];
        end
    endgenerate

    // Stage 2 output register and valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.result       <= MIDPOINT;
            bus.result_valid <= 1'b0;
        end else begin
            bus.result_valid <= r_v1;
            if (r_v1) bus.result <= w_res;
        end
    end
endmodule

// File: doc/adlib_channel_fb.md
# adlib_channel_fb

Parametrised second-generation FM channel for the AdLib (OPL2-compatible) sound path. It is a two-operator channel with register decode, operator feedback (Cn[3:1]), a sample-strobe-driven two-stage output pipeline, configurable output width with saturation, and a valid strobe. One instance per channel sits between the AdLib register bus and the channel mixer.

## Interface
- `N`, default 0: channel index 0..8; matches A/B/C register low nibble.
- `OPN`, default 0: operator slot of op1; op2 is at `OPN+3`.
- `OUT_W`, default 16: output width, 8..24, offset-binary.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `a` input 8: AdLib register address.
- `din` input 8: register write data.
- `regwr` input 1: one-cycle register write strobe.
- `sample_stb` input 1: one-cycle sample-rate tick.
- `result` output OUT_W: channel sample, offset-binary; midpoint = 1<<(OUT_W-1).
- `result_valid` output 1: one-cycle pulse when `result` updates.

## Operation
- Decodes 2n/4n/6n/8n/En for slots `OPN` and `OPN+3`, and An/Bn/Cn for `a[3:0]==N`. These go to the existing operator and oscillator blocks.
- A Cn write latches `alg=din[0]` and `fb=din[3:1]`. Reset value is 0 for both.
- op1 signed contribution: `c1 = ±scaled1[13:0]`, as a 15-bit signed value. The sign comes from the op1 wave sign.
- Feedback history `h0`, `h1` (15-bit signed each):
  - `fbsum = h0 + h1`, 16-bit signed.
  - `fbofs = 0` when `fb==0`; otherwise the low 6 bits of `fbsum >>> (15-fb)`.
- op1 multiplier input = `{op1wave,2'b00} + fbofs`, modulo 64.
- op2 multiplier input:
  - `alg=1`: `{op2wave,2'b00}`.
  - `alg=0`: `{op2wave,2'b00} + scaled1[13:8]`, modulo 64.
- Stage 1, on `sample_stb`, registers two terms:
  - `alg=1`: `s1 = c1`; `s2 = ±scaled2[14:0]` using the op2 sign.
  - `alg=0`: `s1 = 0`; `s2 = ±scaled2[14:0]` with sign = op1 sign XOR op2 sign.
- Stage 1 also shifts the history: `h1<=h0`, `h0<=c1`. The history updates regardless of `alg`.
- Stage 2, one cycle after stage 1:
  - `sum = s1 + s2`, 17-bit signed.
  - `v = clamp(sum, -32768, 32767)`.
  - Scale `v` to OUT_W: `<<< (OUT_W-16)` when OUT_W>16, `>>> (16-OUT_W)` when OUT_W<16 (arithmetic shift).
  - Invert the MSB to get offset-binary, register into `result`, pulse `result_valid`.
- Key-on rising edge (Bn write with `din[5]=1` while the key is currently 0) clears `h0` and `h1` in that cycle.
- `result` holds its value between strobes.

## Timing
- Reset values:
  - `result` = midpoint.
  - `result_valid` = 0.
  - `alg`, `fb`, `h0`, `h1`, `s1`, `s2`, key state all 0.
  - Pipeline valid bits cleared.
- Latency: `sample_stb` at cycle T gives `result` and `result_valid=1` at T+2.
- Back-to-back strobes on consecutive cycles are legal; a result is produced every cycle.
- A Cn or Bn write in the same cycle as `sample_stb`: stage 1 uses the old `alg`/`fb`/history. The new value takes effect from the next strobe.
- Key-on clear in the same cycle as `sample_stb`: the clear wins. `h0=h1=0` afterwards, and stage 1 still uses the old history for its feedback.
- Reset mid-pipeline: in-flight samples are discarded and no `result_valid` pulse is issued for them.
- Saturation is a boundary case: |sum| > 32767 clamps silently, with no wrap.

## Configuration
- `ADLIB_FEEDBACK_EN` defined: feedback path, `fb` register and history are implemented as described.
- Not defined:
  - `fbofs` is tied to 0 and the history registers are omitted.
  - `din[3:1]` of a Cn write is ignored.
  - All other behaviour and the latency are unchanged.

## Structure
- Package `adlib_pkg`:
  - Register group constants (2n, 4n, 6n, 8n, An, Bn, Cn, En).
  - Widths: phase 6, magnitude 14/15, sum 17.
  - Sign-magnitude-to-signed and offset-binary conversion functions.
  - Clamp function.
- Sub-module `adlib_fb_history`:
  - Holds `h0`/`h1`, shift-on-strobe, key-on clear, `fbofs` computation.
  - Wholly excluded when `ADLIB_FEEDBACK_EN` is undefined.
- Operators, oscillator and multipliers reuse the existing codebase blocks.

## Test plan
- Reset, then idle with no strobe: `result`=0x8000 (OUT_W=16) and `result_valid`=0 indefinitely.
- `sample_stb` at T with `alg=1` and forced terms `s1=+16383`, `s2=+32767`: `result`=0xFFFF (saturated) with `result_valid` at T+2. Negative mirror gives 0x0000.
- OUT_W=12 with `sum=+4096`: `result`=0x800+0x100=0x900. OUT_W=20 with the same sum: `result`=0x80000+0x10000=0x90000.
- `fb=7`, `h0=h1=0x1000`: `fbofs` = low 6 bits of (0x2000>>>8) = 0x20. op1 phase offset observed as 32. `fb=0` gives offset 0.
- Cn write (`alg` 0→1) in the same cycle as `sample_stb`: that sample uses FM (`s1=0`); the next strobe uses additive.
- Key-on rising edge with nonzero history: `h0=h1=0` next cycle, and the next sample has `fbofs=0`. Reset asserted at T+1 after a strobe: no `result_valid` pulse and `result`=midpoint.
